// File: rtl/bp_be_stride_pf_gen.sv
// ----------------------------------------------------------------------------
// bp_be_stride_pf_gen
//
// Stride prefetch request generator fed by the backend Reference Prediction
// Table. A confirmed stride prediction, together with the effective address
// of the triggering load, starts a burst of virtual prefetch addresses
// (eff_addr + k*stride, k = 1..D). These are presented toward the D$
// prefetch port. The burst depth D depends on the RPT discovery flags:
// confirm -> pf_max_degree_p, start -> 1, otherwise pf_degree_p.
//
// Valid/ready contract (single statement for the whole block):
//   A request transfers in any cycle where pf_v_o & pf_ready_i. While
//   pf_v_o=1 and pf_ready_i=0, pf_vaddr_o and pf_pc_o hold stable, and
//   pf_v_o only drops without a handshake when flush_i aborts the burst.
//
// Optional feature: define BP_BE_PF_PAGE_FILTER_EN to end a burst, without
// issuing the request, once the next address leaves the 4 KiB page of the
// base (triggering) address. The default build issues every request.
//
// Parameters:
//   vaddr_width_p    virtual address width (39 in the default processor cfg)
//   stride_width_p   width of the incoming two's-complement stride
//   pf_degree_p      burst length for an ordinary stride hit
//   pf_max_degree_p  burst length on confirmed discovery (>= pf_degree_p)
//   drop_cnt_width_p width of the saturating drop counter
//
// Ports:
//   clk_i, reset_n_i     clock, asynchronous active-low reset
//   stride_v_i           stride prediction valid (single-cycle pulse)
//   stride_i             signed stride
//   pc_i                 PC of the striding load
//   eff_addr_i           effective address of the triggering load
//   start_discovery_i    RPT started a new discovery on this trigger
//   confirm_discovery_i  RPT confirmed discovery on this trigger
//   flush_i              synchronous abort of any burst in progress
//   pf_v_o, pf_vaddr_o, pf_pc_o, pf_ready_i   prefetch request channel
//   busy_o               burst in progress; triggers are dropped
//   drop_cnt_o           saturating count of dropped triggers
//   dbg_state_o          current FSM state (0 = e_idle, 1 = e_issue)
// ----------------------------------------------------------------------------
module bp_be_stride_pf_gen #(
    parameter int vaddr_width_p    = 39,
    parameter int stride_width_p   = 8,
    parameter int pf_degree_p      = 2,
    parameter int pf_max_degree_p  = 4,
    parameter int drop_cnt_width_p = 8
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic                        stride_v_i,
    input  logic [stride_width_p-1:0]   stride_i,
    input  logic [vaddr_width_p-1:0]    pc_i,
    input  logic [vaddr_width_p-1:0]    eff_addr_i,
    input  logic                        start_discovery_i,
    input  logic                        confirm_discovery_i,
    input  logic                        flush_i,
    output logic                        pf_v_o,
    output logic [vaddr_width_p-1:0]    pf_vaddr_o,
    output logic [vaddr_width_p-1:0]    pf_pc_o,
    input  logic                        pf_ready_i,
    output logic                        busy_o,
    output logic [drop_cnt_width_p-1:0] drop_cnt_o,
    output logic                        dbg_state_o
);

    localparam int rem_w = $clog2(pf_max_degree_p + 1);

    typedef enum logic {
        e_idle  = 1'b0,
        e_issue = 1'b1
    } state_e;

    state_e                        r_state;
    state_e                        w_state_nxt;
    logic                          w_busy;

    logic [vaddr_width_p-1:0]      r_next;
    logic [vaddr_width_p-1:0]      r_step;
    logic [vaddr_width_p-1:0]      r_pc;
    logic [rem_w-1:0]              r_remaining;
    logic                          r_pf_v;
    logic [drop_cnt_width_p-1:0]   r_drop_cnt;

    logic                          w_trigger;
    logic                          w_accept;
    logic                          w_drop;
    logic                          w_hs;
    logic                          w_last;
    logic [vaddr_width_p-1:0]      w_step;
    logic [vaddr_width_p-1:0]      w_first_addr;
    logic [vaddr_width_p-1:0]      w_adv_addr;
    logic [rem_w-1:0]              w_degree;
    logic                          w_first_ok;
    logic                          w_adv_ok;

    // A zero stride is not a trigger at all, so it is neither accepted nor
    // counted as a drop.
    assign w_trigger = stride_v_i && (stride_i != '0);
    assign w_accept  = w_trigger && (r_state == e_idle) && !flush_i;
    assign w_drop    = w_trigger && !w_accept;

    assign w_hs      = r_pf_v && pf_ready_i;
    assign w_last    = w_hs && (r_remaining == rem_w'(1));

    assign w_step       = {{(vaddr_width_p - stride_width_p){stride_i[stride_width_p-1]}}, stride_i};
    assign w_first_addr = eff_addr_i + w_step;
    assign w_adv_addr   = r_next + r_step;

    // Confirm wins over start when the RPT raises both.
    assign w_degree = confirm_discovery_i ? rem_w'(pf_max_degree_p)
                    : start_discovery_i   ? rem_w'(1)
                    :                       rem_w'(pf_degree_p);

`ifdef BP_BE_PF_PAGE_FILTER_EN
    // The base address is only needed to judge page crossings.
    logic [vaddr_width_p-1:0] r_base;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_base <= '0;
        end else if (w_accept) begin
            r_base <= eff_addr_i;
        end
    end

    assign w_first_ok = (eff_addr_i[vaddr_width_p-1:12] == w_first_addr[vaddr_width_p-1:12]);
    assign w_adv_ok   = (r_base[vaddr_width_p-1:12]     == w_adv_addr[vaddr_width_p-1:12]);
`else
    assign w_first_ok = 1'b1;
    assign w_adv_ok   = 1'b1;
`endif

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= e_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state / outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        case (r_state)
            e_idle: begin
                if (w_accept) begin
                    w_state_nxt = e_issue;
                end
            end
            e_issue: begin
                w_busy = 1'b1;
                if (flush_i) begin
                    w_state_nxt = e_idle;
                end else if (!r_pf_v) begin
                    // Request suppressed by the page filter: burst ends.
                    w_state_nxt = e_idle;
                end else if (w_last) begin
                    w_state_nxt = e_idle;
                end
            end
            default: begin
                w_state_nxt = e_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Burst datapath. r_pf_v is the registered request valid; it is
    // computed one cycle ahead so that a request the page filter rejects
    // never appears on pf_v_o.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_next      <= '0;
            r_step      <= '0;
            r_pc        <= '0;
            r_remaining <= '0;
            r_pf_v      <= 1'b0;
        end else if (w_accept) begin
            r_next      <= w_first_addr;
            r_step      <= w_step;
            r_pc        <= pc_i;
            r_remaining <= w_degree;
            r_pf_v      <= w_first_ok;
        end else if (r_state == e_issue) begin
            if (flush_i) begin
                r_pf_v <= 1'b0;
            end else if (w_hs) begin
                r_next      <= w_adv_addr;
                r_remaining <= r_remaining - rem_w'(1);
                r_pf_v      <= !w_last && w_adv_ok;
            end
        end
    end

    // ------------------------------------------------------------------
    // Saturating drop counter; survives flush, cleared only by reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != {drop_cnt_width_p{1'b1}})) begin
            r_drop_cnt <= r_drop_cnt + drop_cnt_width_p'(1);
        end
    end

    assign pf_v_o      = r_pf_v;
    assign pf_vaddr_o  = r_next;
    assign pf_pc_o     = r_pc;
    assign busy_o      = w_busy;
    assign drop_cnt_o  = r_drop_cnt;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_bp_be_stride_pf_gen.sv
module tb_bp_be_stride_pf_gen;

  localparam int VW = 39;
  localparam int SW = 8;
  localparam int DW = 8;

  logic          clk;
  logic          reset_n;
  logic          stride_v;
  logic [SW-1:0] stride;
  logic [VW-1:0] pc;
  logic [VW-1:0] eff_addr;
  logic          start_disc;
  logic          confirm_disc;
  logic          flush;
  logic          pf_v;
  logic [VW-1:0] pf_vaddr;
  logic [VW-1:0] pf_pc;
  logic          pf_ready;
  logic          busy;
  logic [DW-1:0] drop_cnt;
  logic          dbg_state;

  int checks;
  int errors;

  bp_be_stride_pf_gen #(
    .vaddr_width_p   (VW),
    .stride_width_p  (SW),
    .pf_degree_p     (2),
    .pf_max_degree_p (4),
    .drop_cnt_width_p(DW)
  ) dut (
    .clk_i              (clk),
    .reset_n_i          (reset_n),
    .stride_v_i         (stride_v),
    .stride_i           (stride),
    .pc_i               (pc),
    .eff_addr_i         (eff_addr),
    .start_discovery_i  (start_disc),
    .confirm_discovery_i(confirm_disc),
    .flush_i            (flush),
    .pf_v_o             (pf_v),
    .pf_vaddr_o         (pf_vaddr),
    .pf_pc_o            (pf_pc),
    .pf_ready_i         (pf_ready),
    .busy_o             (busy),
    .drop_cnt_o         (drop_cnt),
    .dbg_state_o        (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; sample point is 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic trigger(input logic [VW-1:0] a, input logic [SW-1:0] s,
                         input logic [VW-1:0] p, input logic st, input logic cf);
    stride_v     = 1'b1;
    stride       = s;
    eff_addr     = a;
    pc           = p;
    start_disc   = st;
    confirm_disc = cf;
  endtask

  task automatic clear_trigger();
    stride_v     = 1'b0;
    stride       = '0;
    start_disc   = 1'b0;
    confirm_disc = 1'b0;
  endtask

  task automatic test_reset();
    stride_v = 1'b0; stride = '0; pc = '0; eff_addr = '0;
    start_disc = 1'b0; confirm_disc = 1'b0; flush = 1'b0; pf_ready = 1'b1;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    tick(); tick();
    checks++; if (pf_v !== 1'b0) begin errors++; $display("FAIL reset_pf_v got %0h exp 0", pf_v); end
    checks++; if (pf_vaddr !== '0) begin errors++; $display("FAIL reset_vaddr got %0h exp 0", pf_vaddr); end
    checks++; if (pf_pc !== '0) begin errors++; $display("FAIL reset_pc got %0h exp 0", pf_pc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0h exp 0", busy); end
    checks++; if (drop_cnt !== 8'h00) begin errors++; $display("FAIL reset_drop got %0h exp 0", drop_cnt); end
    checks++; if (dbg_state !== 1'b0) begin errors++; $display("FAIL reset_state got %0h exp 0", dbg_state); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    pf_ready = 1'b1;
    trigger(39'h1000, 8'h40, 39'h400, 1'b0, 1'b0);
    tick(); clear_trigger();
    checks++; if (pf_v !== 1'b1) begin errors++; $display("FAIL basic_v0 got %0h exp 1", pf_v); end
    checks++; if (pf_vaddr !== 39'h1040) begin errors++; $display("FAIL basic_a0 got %0h exp 1040", pf_vaddr); end
    checks++; if (pf_pc !== 39'h400) begin errors++; $display("FAIL basic_pc got %0h exp 400", pf_pc); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %0h exp 1", busy); end
    tick();
    checks++; if (pf_v !== 1'b1) begin errors++; $display("FAIL basic_v1 got %0h exp 1", pf_v); end
    checks++; if (pf_vaddr !== 39'h1080) begin errors++; $display("FAIL basic_a1 got %0h exp 1080", pf_vaddr); end
    tick();
    checks++; if (pf_v !== 1'b0) begin errors++; $display("FAIL basic_end_v got %0h exp 0", pf_v); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_end_busy got %0h exp 0", busy); end
  endtask

  task automatic test_confirm_backpressure();
    logic [VW-1:0] exp_a;
    pf_ready = 1'b0;
    trigger(39'h2000, 8'hF8, 39'h500, 1'b0, 1'b1);
    tick(); clear_trigger();
    for (int i = 0; i < 3; i++) begin
      checks++; if (pf_v !== 1'b1 || pf_vaddr !== 39'h1FF8 || pf_pc !== 39'h500) begin
        errors++; $display("FAIL stall_hold%0d got v=%0h a=%0h pc=%0h exp v=1 a=1ff8 pc=500", i, pf_v, pf_vaddr, pf_pc);
      end
      tick();
    end
    pf_ready = 1'b1;
    exp_a = 39'h2000;
    for (int k = 1; k <= 4; k++) begin
      exp_a = exp_a - 39'h8;
      checks++; if (pf_v !== 1'b1 || pf_vaddr !== exp_a) begin
        errors++; $display("FAIL confirm_req%0d got v=%0h a=%0h exp v=1 a=%0h", k, pf_v, pf_vaddr, exp_a);
      end
      tick();
    end
    checks++; if (pf_v !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL confirm_end got v=%0h busy=%0h exp 0 0", pf_v, busy);
    end
  endtask

  task automatic test_drops_start_zero();
    pf_ready = 1'b1;
    trigger(39'h3000, 8'h10, 39'h600, 1'b0, 1'b0);
    tick();
    trigger(39'h9000, 8'h20, 39'h700, 1'b0, 1'b0);
    tick(); clear_trigger();
    checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL drop_busy got %0h exp 1", drop_cnt); end
    checks++; if (pf_v !== 1'b1 || pf_vaddr !== 39'h3020 || pf_pc !== 39'h600) begin
      errors++; $display("FAIL drop_unaffected got v=%0h a=%0h pc=%0h exp v=1 a=3020 pc=600", pf_v, pf_vaddr, pf_pc);
    end
    tick();
    trigger(39'h4000, 8'h08, 39'h800, 1'b1, 1'b0);
    tick(); clear_trigger();
    checks++; if (pf_v !== 1'b1 || pf_vaddr !== 39'h4008) begin
      errors++; $display("FAIL start_req got v=%0h a=%0h exp v=1 a=4008", pf_v, pf_vaddr);
    end
    tick();
    checks++; if (pf_v !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL start_single got v=%0h busy=%0h exp 0 0", pf_v, busy);
    end
    trigger(39'h5000, 8'h00, 39'h900, 1'b0, 1'b0);
    tick(); clear_trigger();
    checks++; if (pf_v !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL zero_stride got v=%0h busy=%0h exp 0 0", pf_v, busy);
    end
    checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL zero_nodrop got %0h exp 1", drop_cnt); end
  endtask

  task automatic test_back_to_back();
    pf_ready = 1'b1;
    trigger(39'h5000, 8'h04, 39'hA00, 1'b0, 1'b0);
    tick(); clear_trigger();
    tick();
    // final handshake cycle: this trigger is dropped
    trigger(39'h6000, 8'h04, 39'hB00, 1'b0, 1'b0);
    tick();
    checks++; if (busy !== 1'b0 || pf_v !== 1'b0) begin
      errors++; $display("FAIL b2b_idle got busy=%0h v=%0h exp 0 0", busy, pf_v);
    end
    checks++; if (drop_cnt !== 8'd2) begin errors++; $display("FAIL b2b_drop got %0h exp 2", drop_cnt); end
    // first idle cycle: trigger accepted
    tick(); clear_trigger();
    checks++; if (pf_v !== 1'b1 || pf_vaddr !== 39'h6004 || pf_pc !== 39'hB00) begin
      errors++; $display("FAIL b2b_accept got v=%0h a=%0h pc=%0h exp v=1 a=6004 pc=b00", pf_v, pf_vaddr, pf_pc);
    end
    tick();
    checks++; if (pf_vaddr !== 39'h6008) begin errors++; $display("FAIL b2b_a1 got %0h exp 6008", pf_vaddr); end
    tick();
  endtask

  task automatic test_flush();
    pf_ready = 1'b1;
    trigger(39'h7000, 8'h10, 39'hC00, 1'b0, 1'b1);
    tick(); clear_trigger();
    tick();
    checks++; if (pf_v !== 1'b1 || pf_vaddr !== 39'h7020) begin
      errors++; $display("FAIL flush_pre got v=%0h a=%0h exp v=1 a=7020", pf_v, pf_vaddr);
    end
    pf_ready = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (pf_v !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL flush_abort got v=%0h busy=%0h exp 0 0", pf_v, busy);
    end
    // trigger coincident with flush in idle is dropped
    flush = 1'b1;
    trigger(39'h7800, 8'h10, 39'hC00, 1'b0, 1'b0);
    tick(); clear_trigger(); flush = 1'b0;
    checks++; if (busy !== 1'b0 || pf_v !== 1'b0) begin
      errors++; $display("FAIL flush_trig got busy=%0h v=%0h exp 0 0", busy, pf_v);
    end
    checks++; if (drop_cnt !== 8'd3) begin errors++; $display("FAIL flush_drop got %0h exp 3", drop_cnt); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_stay_idle got %0h exp 0", busy); end
    pf_ready = 1'b1;
  endtask

  task automatic test_saturation();
    pf_ready = 1'b0;
    trigger(39'h8000, 8'h10, 39'hD00, 1'b0, 1'b1);
    tick();
    confirm_disc = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (i == 99) begin
        checks++; if (drop_cnt !== 8'd103) begin errors++; $display("FAIL sat_mid got %0d exp 103", drop_cnt); end
      end
    end
    clear_trigger();
    checks++; if (drop_cnt !== 8'hFF) begin errors++; $display("FAIL sat_full got %0h exp ff", drop_cnt); end
    checks++; if (pf_v !== 1'b1 || pf_vaddr !== 39'h8010) begin
      errors++; $display("FAIL sat_burst_held got v=%0h a=%0h exp v=1 a=8010", pf_v, pf_vaddr);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (busy !== 1'b0 || drop_cnt !== 8'hFF) begin
      errors++; $display("FAIL sat_flush got busy=%0h drop=%0h exp 0 ff", busy, drop_cnt);
    end
    pf_ready = 1'b1;
  endtask

  task automatic test_page_filter();
    pf_ready = 1'b1;
    trigger(39'h1FC0, 8'h40, 39'hE00, 1'b0, 1'b0);
    tick(); clear_trigger();
`ifdef BP_BE_PF_PAGE_FILTER_EN
    checks++; if (pf_v !== 1'b0) begin errors++; $display("FAIL pg_suppress got %0h exp 0", pf_v); end
    tick();
    checks++; if (busy !== 1'b0 || pf_v !== 1'b0) begin
      errors++; $display("FAIL pg_end got busy=%0h v=%0h exp 0 0", busy, pf_v);
    end
    // crossing in the middle of a burst
    trigger(39'h1F80, 8'h40, 39'hE00, 1'b0, 1'b0);
    tick(); clear_trigger();
    checks++; if (pf_v !== 1'b1 || pf_vaddr !== 39'h1FC0) begin
      errors++; $display("FAIL pg_mid_first got v=%0h a=%0h exp v=1 a=1fc0", pf_v, pf_vaddr);
    end
    tick();
    checks++; if (pf_v !== 1'b0) begin errors++; $display("FAIL pg_mid_suppress got %0h exp 0", pf_v); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pg_mid_end got %0h exp 0", busy); end
    checks++; if (drop_cnt !== 8'hFF) begin errors++; $display("FAIL pg_nodrop got %0h exp ff", drop_cnt); end
`else
    checks++; if (pf_v !== 1'b1 || pf_vaddr !== 39'h2000) begin
      errors++; $display("FAIL pg_a0 got v=%0h a=%0h exp v=1 a=2000", pf_v, pf_vaddr);
    end
    tick();
    checks++; if (pf_v !== 1'b1 || pf_vaddr !== 39'h2040) begin
      errors++; $display("FAIL pg_a1 got v=%0h a=%0h exp v=1 a=2040", pf_v, pf_vaddr);
    end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pg_end got %0h exp 0", busy); end
`endif
  endtask

  task automatic test_async_reset();
    pf_ready = 1'b1;
    trigger(39'h8000, 8'h20, 39'h888, 1'b0, 1'b1);
    tick(); clear_trigger();
    tick();
    checks++; if (pf_v !== 1'b1 || pf_vaddr !== 39'h8040) begin
      errors++; $display("FAIL ar_pre got v=%0h a=%0h exp v=1 a=8040", pf_v, pf_vaddr);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (pf_v !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL ar_ctrl got v=%0h busy=%0h exp 0 0", pf_v, busy);
    end
    checks++; if (pf_vaddr !== '0 || pf_pc !== '0) begin
      errors++; $display("FAIL ar_data got a=%0h pc=%0h exp 0 0", pf_vaddr, pf_pc);
    end
    checks++; if (drop_cnt !== 8'h00) begin errors++; $display("FAIL ar_drop got %0h exp 0", drop_cnt); end
    #1 reset_n = 1'b1;
    tick();
    checks++; if (pf_v !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL ar_no_resume got v=%0h busy=%0h exp 0 0", pf_v, busy);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_confirm_backpressure();
    test_drops_start_zero();
    test_back_to_back();
    test_flush();
    test_saturation();
    test_page_filter();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
